// File: rtl/w5300_tx_frame_buffer_pkg.sv
// Shared types and constants for the W5300 transmit frame buffer.
// Bank word 0 carries the frame length in bytes; payload follows.
package w5300_tx_frame_buffer_pkg;

    localparam int TX_LEN_WORD = 0;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_COMMIT
    } tx_wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_BUSY
    } tx_rd_state_t;

    function automatic logic [15:0] frame_len(
        input logic [15:0] words,
        input logic        odd
    );
        return (words << 1) - {15'd0, odd};
    endfunction

endpackage

// File: rtl/w5300_tx_dpram.sv
// Simple dual-port RAM holding both frame banks.
// One write port, one registered read port.
module w5300_tx_dpram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array is left as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/w5300_tx_frame_buffer.sv
// Ping-pong frame buffer feeding the W5300 driver transmit path.
// Writer fills one bank while the driver drains the other.
module w5300_tx_frame_buffer
    import w5300_tx_frame_buffer_pkg::*;
#(
    parameter int ETH_TX_BUFFER_WIDTH = 16,
    parameter int BANK_AW             = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [15:0]                    s_data,
    input  logic                           s_valid,
    input  logic                           s_last,
    input  logic                           s_odd,
    output logic                           s_ready,
    output logic                           frame_drop,
    output logic                           eth_tx_req,
    input  logic [ETH_TX_BUFFER_WIDTH-1:0] eth_tx_buffer_addr,
    output logic [15:0]                    eth_tx_buffer_data,
    input  logic                           eth_op_state
);

    localparam logic [BANK_AW-1:0] MAX_WORDS = {BANK_AW{1'b1}};

    tx_wr_state_t wst, wst_n;
    tx_rd_state_t rst_q, rst_n_q;

    logic                    rst_done;
    logic [1:0]              full;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0][BANK_AW-1:0] words_q;
    logic [BANK_AW-1:0]      wcnt, wcnt_n, wnext;
    logic                    dropping, drop_n;
    logic                    odd_q, odd_n;
    logic                    seen_last, seen_n;
    logic                    commit;
    logic                    release_bank;
    logic                    we;
    logic [BANK_AW:0]        waddr;
    logic [15:0]             wdata;
    logic [BANK_AW-1:0]      rd_addr;
    logic                    addr_unused;

    assign rd_addr     = eth_tx_buffer_addr[BANK_AW-1:0];
    assign addr_unused = ^eth_tx_buffer_addr[ETH_TX_BUFFER_WIDTH-1:BANK_AW];
    assign wnext       = wcnt + 1'b1;
    assign eth_tx_req  = (rst_q != R_REQ);

    always_comb begin
        wst_n      = wst;
        wcnt_n     = wcnt;
        drop_n     = dropping;
        odd_n      = odd_q;
        s_ready    = 1'b0;
        frame_drop = 1'b0;
        we         = 1'b0;
        commit     = 1'b0;
        waddr      = {wr_bank, wnext};
        wdata      = s_data;
        unique case (wst)
            W_IDLE: begin
                s_ready = rst_done & ~full[wr_bank];
                waddr   = {wr_bank, BANK_AW'(1)};
                if (s_valid && s_ready) begin
                    we     = 1'b1;
                    wcnt_n = BANK_AW'(1);
                    odd_n  = s_odd;
                    drop_n = 1'b0;
                    wst_n  = s_last ? W_COMMIT : W_FILL;
                end
            end
            W_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (dropping) begin
                        if (s_last) begin
                            frame_drop = 1'b1;
                            drop_n     = 1'b0;
                            wst_n      = W_IDLE;
                        end
                    end else begin
                        we     = 1'b1;
                        wcnt_n = wnext;
                        odd_n  = s_odd;
                        if (s_last) begin
                            wst_n = W_COMMIT;
                        end else if (wnext == MAX_WORDS) begin
                            // Bank is full and more data follows.
                            drop_n = 1'b1;
                        end
                    end
                end
            end
            W_COMMIT: begin
                we     = 1'b1;
                commit = 1'b1;
                waddr  = {wr_bank, BANK_AW'(TX_LEN_WORD)};
                wdata  = frame_len(16'(wcnt), odd_q);
                wst_n  = W_IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        rst_n_q      = rst_q;
        seen_n       = seen_last;
        release_bank = 1'b0;
        unique case (rst_q)
            R_IDLE: begin
                if (full[rd_bank]) rst_n_q = R_REQ;
            end
            R_REQ: begin
                if (!eth_op_state) begin
                    rst_n_q = R_BUSY;
                    seen_n  = 1'b0;
                end
            end
            R_BUSY: begin
                if (rd_addr == words_q[rd_bank]) seen_n = 1'b1;
                // A busy window without the last word read was IRQ work.
                if (eth_op_state) begin
                    if (seen_last) begin
                        release_bank = 1'b1;
                        rst_n_q      = R_IDLE;
                    end else begin
                        rst_n_q = R_REQ;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst       <= W_IDLE;
            rst_q     <= R_IDLE;
            rst_done  <= 1'b0;
            wcnt      <= '0;
            dropping  <= 1'b0;
            odd_q     <= 1'b0;
            seen_last <= 1'b0;
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            words_q   <= '0;
        end else begin
            wst       <= wst_n;
            rst_q     <= rst_n_q;
            rst_done  <= 1'b1;
            wcnt      <= wcnt_n;
            dropping  <= drop_n;
            odd_q     <= odd_n;
            seen_last <= seen_n;
            if (commit) begin
                full[wr_bank]    <= 1'b1;
                words_q[wr_bank] <= wcnt;
                wr_bank          <= ~wr_bank;
            end
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    w5300_tx_dpram #(
        .AW(BANK_AW + 1)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr({rd_bank, rd_addr}),
        .rdata(eth_tx_buffer_data)
    );

endmodule
